// File: rtl/ucsbece154a_rf_dump_pkg.sv
// Shared definitions for the register-file dump engine: widths, FSM state
// encoding and the captured-beat record.
package ucsbece154a_rf_dump_pkg;

  localparam int RF_IDX_W = 5;
  localparam int WORD_W   = 32;
  localparam int MAX_REG  = 31;

  typedef enum logic [2:0] {
    RFD_IDLE = 3'd0,
    RFD_READ = 3'd1,
    RFD_SEND = 3'd2,
    RFD_CSUM = 3'd3,
    RFD_FIN  = 3'd4
  } rfd_state_e;

  typedef struct packed {
    logic [RF_IDX_W-1:0] addr;
    logic [WORD_W-1:0]   data;
  } rfd_beat_t;

endpackage

// File: rtl/ucsbece154a_rf_dump.sv
// Walks registers FIRST_REG..LAST_REG through a dedicated RF read port and
// streams {addr,data} beats over valid/ready, optionally closed by an XOR checksum beat.
module ucsbece154a_rf_dump
  import ucsbece154a_rf_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter bit CSUM_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [RF_IDX_W-1:0] rf_a_o,
  input  logic [WORD_W-1:0]   rf_rd_i,
  output logic                dump_valid_o,
  input  logic                dump_ready_i,
  output logic [RF_IDX_W-1:0] dump_addr_o,
  output logic [WORD_W-1:0]   dump_data_o,
  output logic                dump_last_o
);

  if (FIRST_REG > LAST_REG || LAST_REG > MAX_REG || FIRST_REG < 0) begin : g_bad_range
    $error("ucsbece154a_rf_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [RF_IDX_W-1:0] LP_FIRST = RF_IDX_W'(FIRST_REG);
  localparam logic [RF_IDX_W-1:0] LP_LAST  = RF_IDX_W'(LAST_REG);

  rfd_state_e          r_state, w_state_nxt;
  logic [RF_IDX_W-1:0] r_idx,   w_idx_nxt;
  logic [WORD_W-1:0]   r_csum,  w_csum_nxt;
  rfd_beat_t           r_beat,  w_beat_nxt;
  logic                w_at_last;

  // Last-register detection compares against LAST_REG, so idx never wraps.
  assign w_at_last = (r_idx == LP_LAST);
  assign rf_a_o    = r_idx;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_csum_nxt   = r_csum;
    w_beat_nxt   = r_beat;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    dump_valid_o = 1'b0;
    dump_addr_o  = '0;
    dump_data_o  = '0;
    dump_last_o  = 1'b0;

    case (r_state)
      RFD_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_state_nxt = RFD_READ;
          w_idx_nxt   = LP_FIRST;
          w_csum_nxt  = '0;
        end
      end

      RFD_READ: begin
        w_beat_nxt  = '{addr: r_idx, data: rf_rd_i};
        w_csum_nxt  = r_csum ^ rf_rd_i;
        w_state_nxt = RFD_SEND;
      end

      RFD_SEND: begin
        // Beat fields come from the captured register, so they stay stable
        // while the sink stalls; valid never looks at ready.
        dump_valid_o = 1'b1;
        dump_addr_o  = r_beat.addr;
        dump_data_o  = r_beat.data;
        dump_last_o  = !CSUM_EN && w_at_last;
        if (dump_ready_i) begin
          if (w_at_last) begin
            w_state_nxt = CSUM_EN ? RFD_CSUM : RFD_FIN;
          end else begin
            w_idx_nxt   = r_idx + RF_IDX_W'(1);
            w_state_nxt = RFD_READ;
          end
        end
      end

      RFD_CSUM: begin
        dump_valid_o = 1'b1;
        dump_data_o  = r_csum;
        dump_last_o  = 1'b1;
        if (dump_ready_i) begin
          w_state_nxt = RFD_FIN;
        end
      end

      RFD_FIN: begin
        done_o      = 1'b1;
        w_idx_nxt   = LP_FIRST;
        w_state_nxt = RFD_IDLE;
      end

      default: begin
        w_state_nxt = RFD_IDLE;
        w_idx_nxt   = LP_FIRST;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RFD_IDLE;
      r_idx   <= LP_FIRST;
      r_csum  <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_csum  <= w_csum_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

endmodule

// File: tb/tb_ucsbece154a_rf_dump.sv
// Self-checking bench: a cycle-exact vector table on the single-register
// instance plus scoreboarded full dumps on the wide and windowed instances.
module tb_ucsbece154a_rf_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start [3];
  logic        ready [3];
  logic        busy  [3];
  logic        done  [3];
  logic        valid [3];
  logic        last  [3];
  logic [4:0]  rf_a  [3];
  logic [4:0]  addr  [3];
  logic [31:0] rf_rd [3];
  logic [31:0] data  [3];
  logic [31:0] rf    [32];

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] lfsr = 16'hACE1;

  always #5 clk = ~clk;

  assign rf_rd[0] = rf[rf_a[0]];
  assign rf_rd[1] = rf[rf_a[1]];
  assign rf_rd[2] = rf[rf_a[2]];

  ucsbece154a_rf_dump u_full (
    .clk(clk), .reset(reset), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
    .rf_a_o(rf_a[0]), .rf_rd_i(rf_rd[0]), .dump_valid_o(valid[0]), .dump_ready_i(ready[0]),
    .dump_addr_o(addr[0]), .dump_data_o(data[0]), .dump_last_o(last[0])
  );

  ucsbece154a_rf_dump #(.FIRST_REG(8), .LAST_REG(15), .CSUM_EN(1'b0)) u_win (
    .clk(clk), .reset(reset), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
    .rf_a_o(rf_a[1]), .rf_rd_i(rf_rd[1]), .dump_valid_o(valid[1]), .dump_ready_i(ready[1]),
    .dump_addr_o(addr[1]), .dump_data_o(data[1]), .dump_last_o(last[1])
  );

  ucsbece154a_rf_dump #(.FIRST_REG(31), .LAST_REG(31), .CSUM_EN(1'b1)) u_one (
    .clk(clk), .reset(reset), .start_i(start[2]), .busy_o(busy[2]), .done_o(done[2]),
    .rf_a_o(rf_a[2]), .rf_rd_i(rf_rd[2]), .dump_valid_o(valid[2]), .dump_ready_i(ready[2]),
    .dump_addr_o(addr[2]), .dump_data_o(data[2]), .dump_last_o(last[2])
  );

  typedef struct packed {
    logic        start;
    logic        ready;
    logic        busy;
    logic        done;
    logic        valid;
    logic        last;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_val(input int k);
    return (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
  endfunction

  // One dump on instance u; the expected beat stream is derived from first/last/csum.
  task automatic run_dump(input int u, input int first, input int lastr, input bit csum_en,
                          input bit rnd, input int poke_beat, input int abort_beat,
                          input int exp_cycles);
    int n_data, n_exp, beats, cyc;
    bit finished, aborted, prev_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data, x;
    logic        e_last;
    n_data = lastr - first + 1;
    n_exp  = n_data + (csum_en ? 1 : 0);
    beats = 0; cyc = 0; finished = 0; aborted = 0; prev_stall = 0; x = '0;
    start[u] = 1'b1;
    ready[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    cyc = 1;
    while (!finished && cyc < 1000) begin
      if (rnd) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        ready[u] = lfsr[0];
      end else begin
        ready[u] = 1'b1;
      end
      start[u] = (poke_beat >= 0 && beats == poke_beat);
      #1;
      if (prev_stall) check("valid_held", 32'(valid[u]), 32'd1);
      if (valid[u]) begin
        if (beats < n_data) begin
          e_addr = 5'(first + beats);
          e_data = reg_val(first + beats);
          e_last = !csum_en && (beats == n_data - 1);
        end else begin
          e_addr = 5'd0;
          e_data = x;
          e_last = 1'b1;
        end
        check("beat_in_range", 32'(beats < n_exp), 32'd1);
        check("beat_addr", 32'(addr[u]), 32'(e_addr));
        check("beat_data", data[u], e_data);
        check("beat_last", 32'(last[u]), 32'(e_last));
        if (abort_beat >= 0 && beats == abort_beat) begin
          #3 reset = 1'b1;
          #1;
          check("abort_valid", 32'(valid[u]), 32'd0);
          check("abort_busy", 32'(busy[u]), 32'd0);
          check("abort_done", 32'(done[u]), 32'd0);
          check("abort_rf_a", 32'(rf_a[u]), 32'(first));
          aborted = 1;
          finished = 1;
        end else if (ready[u]) begin
          if (beats < n_data) x = x ^ e_data;
          beats++;
        end
      end else begin
        check("idle_addr", 32'(addr[u]), 32'd0);
        check("idle_data", data[u], 32'd0);
        check("idle_last", 32'(last[u]), 32'd0);
      end
      if (!aborted && done[u]) begin
        finished = 1;
        check("done_after_beats", 32'(beats), 32'(n_exp));
        if (exp_cycles > 0) check("done_cycle", 32'(cyc), 32'(exp_cycles));
      end
      prev_stall = valid[u] && !ready[u];
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start[u] = 1'b0;
    ready[u] = 1'b1;
    check("dump_terminated", 32'(finished), 32'd1);
    if (aborted) begin
      repeat (2) begin
        @(posedge clk); #1;
        check("reset_no_done", 32'(done[u]), 32'd0);
        check("reset_no_valid", 32'(valid[u]), 32'd0);
      end
      reset = 1'b0;
      @(posedge clk); #1;
    end else begin
      repeat (4) begin
        @(posedge clk); #1;
        check("post_no_done", 32'(done[u]), 32'd0);
        check("post_idle", 32'(busy[u]), 32'd0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = reg_val(k);
    for (int u = 0; u < 3; u++) begin
      start[u] = 1'b0;
      ready[u] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int u = 0; u < 3; u++) begin
      check("rst_busy", 32'(busy[u]), 32'd0);
      check("rst_done", 32'(done[u]), 32'd0);
      check("rst_valid", 32'(valid[u]), 32'd0);
      check("rst_addr", 32'(addr[u]), 32'd0);
      check("rst_data", data[u], 32'd0);
      check("rst_last", 32'(last[u]), 32'd0);
    end
    check("rst_rf_a_full", 32'(rf_a[0]), 32'd0);
    check("rst_rf_a_win", 32'(rf_a[1]), 32'd8);
    check("rst_rf_a_one", 32'(rf_a[2]), 32'd31);

    // Single-register instance, cycle by cycle: stalls, start while busy,
    // start held through FIN, and a fresh checksum on the second dump.
    //             start ready busy done valid last addr   data
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  32'hDEAD_BEEF};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  32'hDEAD_BEEF};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  32'hDEAD_BEEF};
    vt[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vt[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};

    rf[31] = 32'hDEAD_BEEF;
    for (int i = 0; i < 14; i++) begin
      start[2] = vt[i].start;
      ready[2] = vt[i].ready;
      #1;
      check($sformatf("vec%0d_busy", i), 32'(busy[2]), 32'(vt[i].busy));
      check($sformatf("vec%0d_done", i), 32'(done[2]), 32'(vt[i].done));
      check($sformatf("vec%0d_valid", i), 32'(valid[2]), 32'(vt[i].valid));
      check($sformatf("vec%0d_last", i), 32'(last[2]), 32'(vt[i].last));
      check($sformatf("vec%0d_addr", i), 32'(addr[2]), 32'(vt[i].addr));
      check($sformatf("vec%0d_data", i), data[2], vt[i].data);
      check($sformatf("vec%0d_rf_a", i), 32'(rf_a[2]), 32'd31);
      @(posedge clk); #1;
    end
    start[2] = 1'b0;
    rf[31] = reg_val(31);

    // Full 0..31 dump with ready high: done lands 66 cycles after the start edge.
    run_dump(0, 0, 31, 1'b1, 1'b0, -1, -1, 66);
    // Pseudo-random backpressure, with a stray start pulse during beat 5.
    run_dump(0, 0, 31, 1'b1, 1'b1, 5, -1, 0);
    // Asynchronous reset while beat 10 is on offer.
    run_dump(0, 0, 31, 1'b1, 1'b0, -1, 10, 0);
    // Fresh dump after the abort: starts at reg 0 with a clean checksum.
    run_dump(0, 0, 31, 1'b1, 1'b0, -1, -1, 66);
    // Windowed instance 8..15 without checksum.
    run_dump(1, 8, 15, 1'b0, 1'b0, -1, -1, 17);
    run_dump(1, 8, 15, 1'b0, 1'b1, -1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
